johnson_seq_ctrl: RTL and testbench
===================================

Name: johnson_seq_ctrl

Overview:
- Sequencing controller that owns a WIDTH-stage Johnson (twisted-ring) counter and steps it a programmed number of times per start command.
- Provides run/stop/seed control, one-hot phase decode, busy/done status and detection of illegal seed codes.
- Used by surrounding logic as a multi-phase timing generator: start a run, wait for done, consume the phase strobes.

Parameters:
- WIDTH, 4, Johnson stages; sequence length is 2*WIDTH states.
- LEN_W, 8, width of the run-length input and its internal down-counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  run request, sampled at the rising clock edge.
- len  in  LEN_W  number of steps for the run, sampled with start.
- stop  in  1  abort the current run.
- load  in  1  seed request, honoured only in IDLE.
- seed  in  WIDTH  pattern written to q on load.
- q  out  WIDTH  Johnson counter state.
- phase  out  2*WIDTH  one-hot decode of q.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at the end of a run.
- err  out  1  sticky illegal-seed flag.

Behaviour:
- Reset (async, no clock needed): q=0, state=IDLE, busy=0, done=0, err=0, remaining=0. A reset mid-run aborts the run with no done pulse.
- Johnson step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. For WIDTH=4 the sequence is 0000,0001,0011,0111,1111,1110,1100,1000, then 0000.
- phase[k]=1 iff q is the k-th state of that sequence (k=0 is all-zeros). All phase bits are 0 if q is illegal.
- FSM states: IDLE, RUN, DONE. Each state holds until its exit condition.
- IDLE:
  - q holds.
  - start with len!=0: go to RUN, remaining<=len, q unchanged on this edge.
  - start with len==0: go to DONE, q unchanged.
- RUN:
  - busy=1.
  - Each edge: q steps once and remaining decrements.
  - On the edge where remaining==1: step q and go to DONE.
  - Net result: q advances exactly len times, and busy is high for exactly len cycles.
- DONE: done=1 for exactly one cycle, busy=0, q holds; next state is IDLE.
- Start in RUN or DONE is ignored; no queuing.
- stop:
  - In RUN: next edge goes to IDLE, q holds its current value (no step on that edge), no done pulse, remaining cleared.
  - In IDLE or DONE: no effect.
  - stop beats start on the same edge.
- load (IDLE only):
  - Legal seed (valid Johnson code: form 0…01…1 or 1…10…0, including all-0 and all-1): q<=seed.
  - Illegal seed: q<=0 and err<=1.
  - load beats start on the same edge; the start is dropped.
  - load in RUN or DONE is ignored.
- err: sticky, cleared only by reset. It does not block further runs.
- Counter wrap: q wraps 1000 to 0000 naturally (WIDTH=4). len may exceed 2*WIDTH.
- len=2^LEN_W-1 must run to completion with no overflow of remaining.

Test Plan:
- Reset high 5 cycles, then low -> q=0000, busy=0, done=0, err=0, phase=00000001.
- From q=0000: start, len=3 -> busy high 3 cycles; q goes 0001, 0011, 0111; done pulses once the following cycle; q holds 0111; phase=00001000.
- From q=0000: start, len=9 -> q passes 1000 then 0000, ends at 0001; done pulses once.
- Start, len=10; assert stop after 4 steps (q=1111) -> busy drops, q stays 1111, no done pulse; a start during RUN before the stop has no effect.
- load with seed=1100 in IDLE -> q=1100, err=0. Then load with seed=0101 -> q=0000, err=1, and err stays 1 after a subsequent start, len=2 run (q ends 0011).
- Start, len=0 -> done pulses the next cycle, busy never rises, q unchanged. Start, len=6, then async reset mid-run (between clock edges) -> q=0000 and busy=0 immediately, no done pulse.

Source files
------------

// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: steps a WIDTH-stage Johnson counter a programmed number of
// times per start command.
// Provides stop/seed control, one-hot phase decode, busy/done status and a
// sticky illegal-seed flag.
// Ports:
//   i_clk, i_reset   - rising-edge clock, async active-high reset
//   i_start, i_len   - run request and step count (sampled together in IDLE)
//   i_stop           - abort a run; q holds, no done pulse
//   i_load, i_seed   - seed q in IDLE (illegal codes force q=0 and set err)
//   o_q, o_phase     - counter state and its one-hot decode
//   o_busy, o_done   - RUN indicator, one-cycle end-of-run pulse
//   o_err            - sticky illegal-seed flag
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [LEN_W-1:0]   i_len,
  input  logic               i_stop,
  input  logic               i_load,
  input  logic [WIDTH-1:0]   i_seed,
  output logic [WIDTH-1:0]   o_q,
  output logic [2*WIDTH-1:0] o_phase,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_rem_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_seed_legal;
  logic [WIDTH-1:0] w_q_step;

  // k-th code of the Johnson sequence: k ones filling from the LSB for
  // k <= WIDTH, then zeros filling from the LSB.
  function automatic logic [WIDTH-1:0] f_code(input int k);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (k <= WIDTH) c[i] = (i < k);
      else            c[i] = (i >= k - WIDTH);
    end
    return c;
  endfunction

  // A Johnson code has at most one boundary between adjacent differing bits.
  function automatic logic f_legal(input logic [WIDTH-1:0] s);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (s[i] != s[i+1]) n++;
    end
    return (n <= 1);
  endfunction

  assign w_seed_legal = f_legal(i_seed);
  assign w_q_step     = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        // load has priority; a start on the same edge is dropped
        if (i_load) begin
          if (w_seed_legal) begin
            w_q_nxt = i_seed;
          end else begin
            w_q_nxt   = '0;
            w_err_nxt = 1'b1;
          end
        end else if (i_start) begin
          if (i_len != '0) begin
            w_state_nxt = S_RUN;
            w_rem_nxt   = i_len;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = '0;
        end else begin
          w_q_nxt   = w_q_step;
          w_rem_nxt = r_rem - LEN_W'(1);
          // final step of the run; remaining lands on 0
          if (r_rem == LEN_W'(1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    o_q     = r_q;
    o_err   = r_err;
    o_busy  = (r_state == S_RUN);
    o_done  = (r_state == S_DONE);
    o_phase = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      o_phase[k] = (r_q == f_code(k));
    end
  end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
module tb_johnson_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       stop;
  logic       load;
  logic [3:0] seed;
  logic [3:0] q;
  logic [7:0] phase;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp;
  int n_err;

  johnson_seq_ctrl #(.WIDTH(4), .LEN_W(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_len   (len),
    .i_stop  (stop),
    .i_load  (load),
    .i_seed  (seed),
    .o_q     (q),
    .o_phase (phase),
    .o_busy  (busy),
    .o_done  (done),
    .o_err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outputs snapshot: {q, busy, done, err}
  task automatic chk_st(input string tag, input logic [3:0] eq, input logic eb,
                        input logic ed, input logic ee);
    chk({tag, ".q"},    {28'd0, q}, {28'd0, eq});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    chk({tag, ".err"},  {31'd0, err}, {31'd0, ee});
  endtask

  logic [3:0] seq9 [9];
  int busy_cnt;
  int done_cnt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; len = 8'd0; stop = 1'b0; load = 1'b0; seed = 4'd0;
    seq9 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};

    // ---- reset ----
    repeat (5) tick();
    reset = 1'b0;
    tick();
    chk_st("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("reset.phase", {24'd0, phase}, 32'h01);

    // ---- start len=3 from 0000 ----
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    chk_st("run3.e0", 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("run3.s1", 4'b0001, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("run3.s2", 4'b0011, 1'b1, 1'b0, 1'b0);
    tick(); chk_st("run3.s3", 4'b0111, 1'b0, 1'b1, 1'b0);
    tick(); chk_st("run3.idle", 4'b0111, 1'b0, 1'b0, 1'b0);
    chk("run3.phase", {24'd0, phase}, 32'h08);

    // ---- reseed to 0000, start len=9 (wraps) ----
    load = 1'b1; seed = 4'b0000;
    tick();
    load = 1'b0;
    chk("seed0.q", {28'd0, q}, 32'h0);
    start = 1'b1; len = 8'd9;
    tick();
    start = 1'b0;
    chk("run9.busy0", {31'd0, busy}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("run9.q%0d", i + 1), {28'd0, q}, {28'd0, seq9[i]});
      chk($sformatf("run9.done%0d", i + 1), {31'd0, done}, (i == 8) ? 32'h1 : 32'h0);
    end
    tick();
    chk_st("run9.idle", 4'b0001, 1'b0, 1'b0, 1'b0);
    chk("run9.phase", {24'd0, phase}, 32'h02);

    // ---- start len=10, stray start mid-run, stop after 4 steps ----
    load = 1'b1; seed = 4'b0000;
    tick();
    load = 1'b0;
    start = 1'b1; len = 8'd10;
    tick();
    start = 1'b0;
    tick(); chk("stop.s1", {28'd0, q}, 32'h1);
    start = 1'b1; len = 8'd2;          // ignored in RUN
    tick(); chk("stop.s2", {28'd0, q}, 32'h3);
    start = 1'b0;
    tick(); chk("stop.s3", {28'd0, q}, 32'h7);
    tick(); chk_st("stop.s4", 4'b1111, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_st("stop.idle", 4'b1111, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("stop.hold", 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("stop.phase", {24'd0, phase}, 32'h10);

    // ---- legal and illegal seeds ----
    load = 1'b1; seed = 4'b1100;
    tick();
    chk_st("seed1100", 4'b1100, 1'b0, 1'b0, 1'b0);
    seed = 4'b0101;
    tick();
    load = 1'b0;
    chk_st("seed0101", 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("seed0101.phase", {24'd0, phase}, 32'h01);
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    chk_st("err.run.e0", 4'b0000, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("err.run.s1", 4'b0001, 1'b1, 1'b0, 1'b1);
    tick(); chk_st("err.run.s2", 4'b0011, 1'b0, 1'b1, 1'b1);
    tick(); chk_st("err.run.idle", 4'b0011, 1'b0, 1'b0, 1'b1);

    // ---- load beats start on the same edge ----
    load = 1'b1; seed = 4'b1000; start = 1'b1; len = 8'd5;
    tick();
    load = 1'b0; start = 1'b0;
    chk_st("ldstart.e0", 4'b1000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_st("ldstart.e1", 4'b1000, 1'b0, 1'b0, 1'b1);

    // ---- start len=0 ----
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk_st("len0.e0", 4'b1000, 1'b0, 1'b1, 1'b1);
    tick();
    chk_st("len0.e1", 4'b1000, 1'b0, 1'b0, 1'b1);

    // ---- max length run: 255 steps, 255 mod 8 = 7 -> 1000 from 0000 ----
    load = 1'b1; seed = 4'b0000;
    tick();
    load = 1'b0;
    start = 1'b1; len = 8'd255;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (done) break;
      tick();
    end
    chk("len255.busy_cycles", busy_cnt, 32'd255);
    chk("len255.done_seen", done_cnt, 32'd1);
    chk("len255.q", {28'd0, q}, 32'h8);
    tick();
    chk_st("len255.idle", 4'b1000, 1'b0, 1'b0, 1'b1);

    // ---- async reset mid-run ----
    start = 1'b1; len = 8'd6;
    tick();
    start = 1'b0;
    tick(); chk("arst.s1", {28'd0, q}, 32'h0);
    tick(); chk("arst.s2", {28'd0, q}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk_st("arst.now", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("arst.phase", {24'd0, phase}, 32'h01);
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("arst.no_done", done_cnt, 32'd0);
    chk("arst.q", {28'd0, q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
